// File: rtl/oam_dma_arbiter_pkg.sv
// Shared MMU constants for the OAM DMA block: register address, copy length and DMA states.
package oam_dma_arbiter_pkg;

   localparam logic [15:0] DMA_reg_addr = 16'hFF46;
   localparam int unsigned OAM_DMA_len  = 160;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      XFER
   } dma_state_t;

   // Sources in $E000-$FFFF read through the echo of WRAM.
   function automatic logic [7:0] dma_src_page(input logic [7:0] src_hi);
      return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
   endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU, MMU and OAM signals of the OAM DMA arbiter; master is the arbiter, slave its surroundings.
interface oam_dma_arbiter_if;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_read_en;
   logic        cpu_write_en;
   logic [7:0]  cpu_rdata;
   logic [15:0] mmu_addr;
   logic [7:0]  mmu_wdata;
   logic        mmu_read_en;
   logic        mmu_write_en;
   logic [7:0]  mmu_rdata;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_write_en;
   logic        dma_active;

   modport master (
      input  cpu_addr, cpu_wdata, cpu_read_en, cpu_write_en, mmu_rdata,
      output cpu_rdata, mmu_addr, mmu_wdata, mmu_read_en, mmu_write_en,
      output oam_addr, oam_wdata, oam_write_en, dma_active
   );

   modport slave (
      output cpu_addr, cpu_wdata, cpu_read_en, cpu_write_en, mmu_rdata,
      input  cpu_rdata, mmu_addr, mmu_wdata, mmu_read_en, mmu_write_en,
      input  oam_addr, oam_wdata, oam_write_en, dma_active
   );

endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: start delay, per-byte slot phase, byte index and the DMA bus grant.
module oam_dma_engine
   import oam_dma_arbiter_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BYTE = 4,
   parameter int unsigned START_DELAY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [7:0]  src_hi_i,
   input  logic        bus_free_i,
   output logic [15:0] src_addr_o,
   output logic [7:0]  idx_o,
   output logic        dma_grant_o,
   output logic        dma_active_o
);

   localparam int unsigned PhW  = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
   localparam int unsigned DlyW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [PhW-1:0]  PhLast  = PhW'(CYCLES_PER_BYTE - 1);
   localparam logic [DlyW-1:0] DlyLoad = DlyW'(START_DELAY - 1);
   localparam logic [7:0]      IdxLast = 8'(OAM_DMA_len - 1);

   dma_state_t     state_q, state_d;
   logic [DlyW-1:0] delay_q, delay_d;
   logic [PhW-1:0]  phase_q, phase_d;
   logic [7:0]      idx_q, idx_d;
   logic            done_q, done_d;
   logic            grant;
   logic            slot_end;

   always_comb begin
      state_d  = state_q;
      delay_d  = delay_q;
      phase_d  = phase_q;
      idx_d    = idx_q;
      done_d   = done_q;
      grant    = (state_q == XFER) && !done_q && bus_free_i;
      // A slot that is still missing its byte parks on the last phase until the DMA wins.
      slot_end = (state_q == XFER) && (phase_q == PhLast) && (done_q || grant);

      case (state_q)
         IDLE: ;
         DELAY: begin
            if (delay_q == '0) begin
               state_d = XFER;
            end else begin
               delay_d = delay_q - 1'b1;
            end
         end
         XFER: begin
            if (slot_end) begin
               phase_d = '0;
               done_d  = 1'b0;
               idx_d   = idx_q + 8'd1;
               if (idx_q == IdxLast) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end
            end else begin
               done_d = done_q | grant;
               if (phase_q != PhLast) begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_i) begin
         state_d = DELAY;
         delay_d = DlyLoad;
         phase_d = '0;
         idx_d   = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         delay_q <= '0;
         phase_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         delay_q <= delay_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign src_addr_o   = {dma_src_page(src_hi_i), idx_q};
   assign idx_o        = idx_q;
   assign dma_grant_o  = grant;
   assign dma_active_o = (state_q == XFER);

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU/DMA arbiter in front of the MMU: owns $FF46, blocks low memory during a copy and
// muxes the single MMU bus between the CPU and the DMA engine.
module oam_dma_arbiter
   import oam_dma_arbiter_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BYTE = 4,
   parameter int unsigned START_DELAY     = 4
) (
   input logic              clk,
   input logic              reset,
   oam_dma_arbiter_if.master bus
);

   logic [7:0]  src_hi_q, src_hi_d;
   logic        cpu_access;
   logic        is_dma_reg;
   logic        blocked;
   logic        forward;
   logic        start;
   logic        dma_grant;
   logic        dma_active;
   logic [15:0] src_addr;
   logic [7:0]  idx;

   assign cpu_access = bus.cpu_read_en | bus.cpu_write_en;
   assign is_dma_reg = (bus.cpu_addr == DMA_reg_addr);
   assign blocked    = dma_active && (bus.cpu_addr[15:8] != 8'hFF);
   assign forward    = cpu_access && !is_dma_reg && !blocked;
   assign start      = bus.cpu_write_en && is_dma_reg;

   always_comb begin
      src_hi_d = src_hi_q;
      if (start) begin
         src_hi_d = bus.cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_hi_q <= 8'hFF;
      end else begin
         src_hi_q <= src_hi_d;
      end
   end

   // During XFER only high-page accesses are forwarded, so forward doubles as CPU contention.
   oam_dma_engine #(
      .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
      .START_DELAY     (START_DELAY)
   ) u_engine (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start),
      .src_hi_i     (src_hi_q),
      .bus_free_i   (!forward),
      .src_addr_o   (src_addr),
      .idx_o        (idx),
      .dma_grant_o  (dma_grant),
      .dma_active_o (dma_active)
   );

   always_comb begin
      bus.mmu_addr     = '0;
      bus.mmu_wdata    = '0;
      bus.mmu_read_en  = 1'b0;
      bus.mmu_write_en = 1'b0;
      if (dma_grant) begin
         bus.mmu_addr    = src_addr;
         bus.mmu_read_en = 1'b1;
      end else if (forward) begin
         bus.mmu_addr     = bus.cpu_addr;
         bus.mmu_wdata    = bus.cpu_wdata;
         bus.mmu_read_en  = bus.cpu_read_en;
         bus.mmu_write_en = bus.cpu_write_en;
      end
   end

   always_comb begin
      if (is_dma_reg) begin
         bus.cpu_rdata = src_hi_q;
      end else if (blocked) begin
         bus.cpu_rdata = 8'hFF;
      end else begin
         bus.cpu_rdata = bus.mmu_rdata;
      end
   end

   assign bus.oam_addr     = idx;
   assign bus.oam_wdata    = bus.mmu_rdata;
   assign bus.oam_write_en = dma_grant;
   assign bus.dma_active   = dma_active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed-sequence bench for oam_dma_arbiter with a randomly filled memory behind the MMU port
// and a reference model of the copy schedule, source mapping and CPU routing.
module tb_oam_dma_arbiter;

   localparam int unsigned CPB = 4;
   localparam int unsigned SD  = 4;
   localparam int unsigned LEN = 160;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  idx;
      logic [7:0]  data;
      logic [15:0] maddr;
      logic        mrd;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int unsigned cyc = 0;
   logic [31:0] seed;
   logic [7:0] mem [65536];
   bit written [65536];
   logic [7:0] oam_mem [256];
   ev_t ev_q[$];
   int checks = 0;
   int errors = 0;

   oam_dma_arbiter_if bus ();

   oam_dma_arbiter #(
      .CYCLES_PER_BYTE (CPB),
      .START_DELAY     (SD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] hash8(input logic [31:0] x);
      logic [31:0] h;
      h = x * 32'h9E3779B1;
      h = h ^ (h >> 15);
      return h[23:16];
   endfunction

   // Memory behind the MMU: random background content, overwritten by forwarded CPU writes.
   always @(posedge clk) begin
      if (bus.mmu_write_en) begin
         mem[bus.mmu_addr]     <= bus.mmu_wdata;
         written[bus.mmu_addr] <= 1'b1;
      end
   end

   always_comb begin
      bus.mmu_rdata = written[bus.mmu_addr] ? mem[bus.mmu_addr]
                                            : hash8({16'h0, bus.mmu_addr} ^ seed);
   end

   always @(negedge clk) begin
      if (!reset && bus.oam_write_en) begin
         ev_q.push_back('{cyc: cyc, idx: bus.oam_addr, data: bus.oam_wdata,
                          maddr: bus.mmu_addr, mrd: bus.mmu_read_en});
         oam_mem[bus.oam_addr] = bus.oam_wdata;
      end
   end

   function automatic logic [7:0] ref_byte(input logic [15:0] a);
      return written[a] ? mem[a] : hash8({16'h0, a} ^ seed);
   endfunction

   function automatic logic [15:0] ref_src(input logic [7:0] s, input int unsigned k);
      logic [15:0] a;
      a = {s, 8'h00};
      if (a >= 16'hE000) a = a - 16'h2000;
      return a + 16'(k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
      bus.cpu_read_en  = rd;
      bus.cpu_write_en = wr;
      bus.cpu_addr     = a;
      bus.cpu_wdata    = d;
   endtask

   task automatic idle_cpu();
      drive(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int unsigned wc);
      @(negedge clk);
      drive(1'b0, 1'b1, a, d);
      wc = cyc;
      @(negedge clk);
      idle_cpu();
   endtask

   task automatic cpu_read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
      @(negedge clk);
      drive(1'b1, 1'b0, a, 8'h00);
      #1;
      check(tag, 32'(bus.cpu_rdata), 32'(exp));
      @(negedge clk);
      idle_cpu();
   endtask

   task automatic wait_oam(input bit any, input logic [7:0] k, input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = bus.oam_write_en && (any || bus.oam_addr == k);
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_active(input logic level, input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = (bus.dma_active === level);
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   // Compares one complete copy: byte order, data, source address and (optionally) slot timing.
   task automatic check_xfer(input string tag, input int first, input logic [7:0] s,
                             input int unsigned t0, input bit timed);
      int n;
      int bad;
      int bad_img;
      n = ev_q.size() - first;
      bad = 0;
      bad_img = 0;
      check({tag, "_count"}, 32'(n), 32'(LEN));
      for (int k = 0; k < n && k < int'(LEN); k++) begin
         ev_t e;
         e = ev_q[first + k];
         if (e.idx != 8'(k) || e.maddr != ref_src(s, k) || !e.mrd ||
             e.data != ref_byte(ref_src(s, k))) bad++;
         if (timed && e.cyc != t0 + 32'(k) * CPB) bad++;
      end
      check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
      for (int k = 0; k < int'(LEN); k++) begin
         if (oam_mem[k] !== ref_byte(ref_src(s, k))) bad_img++;
      end
      check({tag, "_oam_image"}, 32'(bad_img), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned wc;
      int unsigned c;
      int base;
      int first;
      bit found50;
      logic [7:0] ic;
      logic [7:0] saved;

      seed = $urandom;
      idle_cpu();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_dma_active", 32'(bus.dma_active), 32'd0);
      check("rst_oam_we", 32'(bus.oam_write_en), 32'd0);
      check("rst_mmu_rd", 32'(bus.mmu_read_en), 32'd0);
      check("rst_mmu_wr", 32'(bus.mmu_write_en), 32'd0);
      cpu_read_check("rst_ff46", 16'hFF46, 8'hFF);

      // Uncontended copy from $C100.
      base = ev_q.size();
      cpu_write(16'hFF46, 8'hC1, wc);
      wait_active(1'b1, 20, "t1_rise_seen");
      check("t1_delay_clocks", cyc - wc - 1, 32'(SD));
      wait_active(1'b0, 1000, "t1_fall_seen");
      check("t1_total_clocks", cyc - wc - 1, 32'(SD + LEN * CPB));
      check_xfer("t1", base, 8'hC1, wc + 1 + SD, 1'b1);

      cpu_write(16'hC005, 8'h5A, wc);
      check("idle_wr_pass", 32'(ref_byte(16'hC005)), 32'h5A);
      cpu_read_check("idle_rd_pass", 16'hC005, 8'h5A);
      cpu_read_check("ff46_readback", 16'hFF46, 8'hC1);

      // Echo-region source with blocked, high-page and contending CPU traffic.
      base = ev_q.size();
      cpu_write(16'hFF46, 8'hE2, wc);
      wait_active(1'b1, 20, "t2_rise_seen");
      repeat (2) @(negedge clk);
      @(negedge clk);
      drive(1'b1, 1'b0, 16'hC000, 8'h00);
      #1;
      check("blk_rd_data", 32'(bus.cpu_rdata), 32'hFF);
      check("blk_rd_strobe", 32'(bus.mmu_read_en && bus.mmu_addr == 16'hC000), 32'd0);
      saved = ref_byte(16'h8000);
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h8000, ~saved);
      #1;
      check("blk_wr_strobe", 32'(bus.mmu_write_en), 32'd0);
      @(negedge clk);
      idle_cpu();
      #1;
      check("blk_wr_dropped", 32'(ref_byte(16'h8000)), 32'(saved));
      @(negedge clk);
      drive(1'b1, 1'b0, 16'hFF80, 8'h00);
      #1;
      check("hi_rd_data", 32'(bus.cpu_rdata), 32'(ref_byte(16'hFF80)));
      check("hi_rd_addr", 32'(bus.mmu_addr), 32'hFF80);
      check("hi_rd_strobe", 32'(bus.mmu_read_en), 32'd1);
      @(negedge clk);
      idle_cpu();

      wait_oam(1'b1, 8'h00, 20, "cont_sync_a");
      wait_oam(1'b1, 8'h00, 20, "cont_sync_b");
      c = cyc;
      ic = bus.oam_addr;
      repeat (3) @(negedge clk);
      for (int i = 0; i < int'(CPB); i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 16'hFF80, 8'h00);
         #1;
         check($sformatf("cont_phase%0d_no_dma", i), 32'(bus.oam_write_en), 32'd0);
      end
      @(negedge clk);
      idle_cpu();
      #1;
      check("cont_held_grant", 32'(bus.oam_write_en), 32'd1);
      check("cont_held_idx", 32'(bus.oam_addr), 32'(ic + 8'd1));
      check("cont_held_cycle", cyc - c, 32'(2 * CPB));
      wait_oam(1'b1, 8'h00, 20, "cont_next_seen");
      check("cont_next_cycle", cyc - c, 32'(2 * CPB + 1));
      check("cont_next_idx", 32'(bus.oam_addr), 32'(ic + 8'd2));
      wait_active(1'b0, 1000, "t2_fall_seen");
      check_xfer("t2", base, 8'hE2, 0, 1'b0);

      // Restart with a new source while byte 50 is being copied.
      base = ev_q.size();
      cpu_write(16'hFF46, 8'h90, wc);
      wait_oam(1'b0, 8'd50, 400, "t3_idx50_seen");
      drive(1'b0, 1'b1, 16'hFF46, 8'hD0);
      c = cyc;
      @(negedge clk);
      idle_cpu();
      wait_active(1'b1, 20, "t3_rise_seen");
      check("t3_restart_delay", cyc - c - 1, 32'(SD));
      wait_active(1'b0, 1000, "t3_fall_seen");
      first = ev_q.size();
      found50 = 1'b0;
      for (int i = base; i < ev_q.size(); i++) begin
         if (ev_q[i].cyc == c && ev_q[i].idx == 8'd50) found50 = 1'b1;
         if (first == ev_q.size() && ev_q[i].cyc > c) first = i;
      end
      check("t3_byte50_written", 32'(found50), 32'd1);
      check_xfer("t3", first, 8'hD0, c + 1 + SD, 1'b1);
      cpu_read_check("t3_ff46", 16'hFF46, 8'hD0);

      // Reset in the middle of a copy.
      cpu_write(16'hFF46, 8'hC3, wc);
      wait_oam(1'b0, 8'd80, 600, "t4_idx80_seen");
      reset = 1'b1;
      #1;
      check("t4_rst_oam_we", 32'(bus.oam_write_en), 32'd0);
      check("t4_rst_active", 32'(bus.dma_active), 32'd0);
      check("t4_rst_mmu_rd", 32'(bus.mmu_read_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      base = ev_q.size();
      repeat (700) @(negedge clk);
      check("t4_no_writes_after", 32'(ev_q.size() - base), 32'd0);
      cpu_read_check("t4_ff46", 16'hFF46, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
